// File: rtl/alu_result_sender_if.sv
// rtl/alu_result_sender_if.sv - ALU result in / UART TX byte out signal bundle
interface alu_result_sender_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] alu_out;
    logic             alu_out_valid;
    logic             tx_busy;
    logic [7:0]       tx_p_data;
    logic             tx_d_valid;

    // master: the sender itself; slave: the ALU/UART environment around it
    modport master (
        input  alu_out,
        input  alu_out_valid,
        input  tx_busy,
        output tx_p_data,
        output tx_d_valid
    );

    modport slave (
        output alu_out,
        output alu_out_valid,
        output tx_busy,
        input  tx_p_data,
        input  tx_d_valid
    );
endinterface

// File: rtl/alu_result_sender.sv
// rtl/alu_result_sender.sv - serializes ALU results LSB byte first to the UART TX
module alu_result_sender #(
    parameter int WIDTH       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_result_sender_if.master     bus,
    input  logic                    err_clr,
    output logic                    sender_busy,
    output logic                    overrun,
    output logic                    timeout
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [3:0]       TO_LIMIT  = 4'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t           r_state,      w_state_nxt;
    logic [WIDTH-1:0] r_shreg,      w_shreg_nxt;
    logic [CNT_W-1:0] r_byte_cnt,   w_byte_cnt_nxt;
    logic [3:0]       r_to_cnt,     w_to_cnt_nxt;
    logic [7:0]       r_tx_p_data,  w_tx_p_data_nxt;
    logic             r_tx_d_valid, w_tx_d_valid_nxt;
    logic             r_overrun,    w_overrun_nxt;
    logic             r_timeout,    w_timeout_nxt;
    logic [3:0]       w_to_inc;
    logic [WIDTH-1:0] w_shreg_shift;

    assign w_shreg_shift = r_shreg >> 8;
    assign w_to_inc      = (r_to_cnt == 4'hF) ? r_to_cnt : r_to_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_byte_cnt   <= '0;
            r_to_cnt     <= '0;
            r_tx_p_data  <= '0;
            r_tx_d_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_tx_p_data  <= w_tx_p_data_nxt;
            r_tx_d_valid <= w_tx_d_valid_nxt;
            r_overrun    <= w_overrun_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_tx_p_data_nxt  = r_tx_p_data;
        w_tx_d_valid_nxt = 1'b0;
        // sticky flags: a same-cycle set overrides err_clr
        w_overrun_nxt    = r_overrun & ~err_clr;
        w_timeout_nxt    = r_timeout & ~err_clr;

        if (bus.alu_out_valid && (r_state != IDLE)) begin
            w_overrun_nxt = 1'b1;
        end

        // the strobe and its byte are loaded on the edge entering SEND
        case (r_state)
            IDLE: begin
                if (bus.alu_out_valid) begin
                    w_shreg_nxt      = bus.alu_out;
                    w_byte_cnt_nxt   = LAST_BYTE;
                    w_tx_p_data_nxt  = bus.alu_out[7:0];
                    w_tx_d_valid_nxt = 1'b1;
                    w_state_nxt      = SEND;
                end
            end
            SEND: begin
                w_to_cnt_nxt = '0;
                w_state_nxt  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_to_cnt_nxt = w_to_inc;
                    if (w_to_inc == TO_LIMIT) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (r_byte_cnt != '0) begin
                        w_shreg_nxt      = w_shreg_shift;
                        w_byte_cnt_nxt   = r_byte_cnt - CNT_W'(1);
                        w_tx_p_data_nxt  = w_shreg_shift[7:0];
                        w_tx_d_valid_nxt = 1'b1;
                        w_state_nxt      = SEND;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.tx_p_data  = r_tx_p_data;
    assign bus.tx_d_valid = r_tx_d_valid;
    assign sender_busy    = (r_state != IDLE);
    assign overrun        = r_overrun;
    assign timeout        = r_timeout;
endmodule

// File: doc/alu_result_sender.md
Name: alu_result_sender

Overview:
- Consumer end of the ALU result interface. Captures a WIDTH-bit ALU result when the unit's result-valid flag pulses.
- Serializes the result into WIDTH/8 bytes, LSB byte first, and hands each byte to the UART transmitter over a valid/busy handshake.
- Sits between the ALU/register-file datapath and the UART TX. It is the sole client of the TX parallel-data port.

Parameters:
- WIDTH, 16, ALU result width. Must be a multiple of 8; NBYTES = WIDTH/8.
- ACK_TIMEOUT, 15, maximum clk cycles spent in WAIT_ACK before abort (4-bit counter).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- alu_out  input  WIDTH  ALU result data
- alu_out_valid  input  1  one-cycle pulse; alu_out is valid in that cycle
- tx_busy  input  1  UART TX busy; high while a frame is being shifted out
- err_clr  input  1  synchronous clear of overrun and timeout
- tx_p_data  output  8  byte presented to UART TX
- tx_d_valid  output  1  one-cycle strobe; tx_p_data is valid in that cycle
- sender_busy  output  1  high whenever state is not IDLE
- overrun  output  1  sticky; a result arrived while sender_busy was high
- timeout  output  1  sticky; TX did not acknowledge within ACK_TIMEOUT cycles

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; shift register, byte counter and timeout counter = 0.
  - tx_p_data = 0, tx_d_valid = 0, overrun = 0, timeout = 0.
- All outputs are registered. sender_busy is a registered or state-decoded Moore output; it must not depend combinationally on inputs.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE: when alu_out_valid = 1, capture alu_out into the shift register, set byte counter = NBYTES-1, go to SEND.
  - SEND: lasts exactly 1 cycle. tx_d_valid = 1 and tx_p_data = shreg[7:0] during this cycle. Go to WAIT_ACK with timeout counter = 0.
  - WAIT_ACK: on tx_busy = 1, go to WAIT_DONE. Otherwise increment the timeout counter. When the counter reaches ACK_TIMEOUT with tx_busy still 0, set timeout = 1 and go to IDLE, discarding the remaining bytes.
  - WAIT_DONE: on tx_busy = 0:
    - byte counter != 0: shift the register right by 8, decrement the counter, go to SEND.
    - byte counter = 0: go to IDLE.
- tx_p_data holds its last driven value outside SEND. tx_d_valid is 0 in every state except SEND.
- Latency: alu_out_valid sampled at edge N → tx_d_valid high in the cycle after edge N (between edges N and N+1).
- With WIDTH = 16, exactly two tx_d_valid strobes occur per accepted result.
- Boundary conditions:
  - alu_out_valid while state != IDLE (including the same cycle the FSM returns to IDLE from WAIT_DONE): result is discarded, overrun set to 1. The in-flight transfer is unaffected.
  - alu_out_valid in the first IDLE cycle after a transfer ends is accepted normally.
  - err_clr and a new overrun/timeout event in the same cycle: set wins.
  - err_clr has no effect on the FSM or data.
  - tx_busy already high on entry to WAIT_ACK: advance to WAIT_DONE on the next edge.
  - tx_busy glitching low in WAIT_ACK has no effect; only a high level advances the state.
  - rst asserted mid-transfer: immediate return to reset values. No partial byte is re-sent after release.
  - Timeout counter saturates and does not wrap. It is reset on every SEND.

Test Plan:
1. Reset, then alu_out = 16'hA55A with a 1-cycle valid; TX model asserts busy 2 cycles after the strobe for 10 cycles → strobes carry 8'h5A then 8'hA5. sender_busy falls after the second busy release. overrun = 0, timeout = 0.
2. During the transfer of 16'h1234, pulse valid with 16'hFFFF → only 8'h34 and 8'h12 are sent. overrun = 1 and stays 1 until err_clr. err_clr pulse → overrun = 0.
3. TX model never raises busy → timeout = 1 exactly 15 cycles after entering WAIT_ACK. FSM returns to IDLE, only 1 strobe observed. A subsequent 16'h00FF is accepted and sent normally.
4. Back-to-back: valid for 16'h0001 and, the first IDLE cycle after completion, 16'h0002 → byte sequence 01, 00, 02, 00; overrun = 0.
5. Assert rst during WAIT_DONE of the first byte of 16'hBEEF → all outputs 0 immediately. After release, no strobes until the next valid.
6. err_clr and an overrun-causing valid in the same cycle → overrun = 1 after the edge.
